// File: rtl/mux4.sv
// Four-way WIDTH-bit data selector; pure combinational passthrough.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // Route the selected channel to the output.
  always_comb begin
    out = i0;
    case (sel)
      2'd0: out = i0;
      2'd1: out = i1;
      2'd2: out = i2;
      2'd3: out = i3;
      default: out = i0;
    endcase
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a one-entry registered output stage.
// The pointer names the highest-priority channel; a granted channel drops to
// lowest priority for the next search.
module rr_arb4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_src
);

  localparam int NCH = 4;
  localparam int IW  = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g;
  logic [IW-1:0]   idx;
  logic            found;
  logic            any_req;
  logic            load;
  logic            take;
  logic [WIDTH-1:0] mux_out;

  assign any_req   = |in_valid;
  assign load      = (state == EMPTY) | out_ready;
  assign take      = load & any_req;
  assign out_valid = (state == FULL);

  // Rotating priority search: first requesting channel at or after ptr.
  always_comb begin
    g     = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + IW'(k);
      if (!found && in_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  // Grant is one-hot on a load with a pending request; held off during reset
  // so no producer sees a handshake that the registers will not capture.
  always_comb begin
    in_ready = '0;
    if (rst_n && take) in_ready[g] = 1'b1;
  end

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .sel (g),
    .out (mux_out)
  );

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  // Next state: a load either refills the stage or drains it to empty.
  always_comb begin
    state_nx = state;
    if (load) state_nx = any_req ? FULL : EMPTY;
  end

  // Capture the granted word and advance the pointer past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      out_src <= '0;
      ptr     <= '0;
    end else if (take) begin
      out     <= mux_out;
      out_src <= g;
      ptr     <= g + 1'b1;
    end
  end

endmodule
